// File: rtl/vend_pkg.sv
// Shared state encoding, coin codes and coin-value lookup for the vending machine.
// Pure types/functions: no latency, no flow control.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_VEND   = 2'd2,
    ST_CHANGE = 2'd3
  } state_t;

  localparam logic [1:0] COIN_5   = 2'b00;
  localparam logic [1:0] COIN_10  = 2'b01;
  localparam logic [1:0] COIN_50  = 2'b10;
  localparam logic [1:0] COIN_100 = 2'b11;

  localparam int COIN_VAL_W = 7;

  function automatic logic [COIN_VAL_W-1:0] coin_value(input logic [1:0] code);
    logic [COIN_VAL_W-1:0] v;
    case (code)
      COIN_5:  v = 7'd5;
      COIN_10: v = 7'd10;
      COIN_50: v = 7'd50;
      default: v = 7'd100;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vend_change_gen.sv
// Greedy change selector: largest coin not exceeding the credit, plus what remains.
// Purely combinational, zero latency; no flow control.
module vend_change_gen
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 8
) (
  input  logic [CREDIT_W-1:0] i_credit,
  output logic [1:0]          o_code,
  output logic [CREDIT_W-1:0] o_remain
);

  localparam int EXT_W = CREDIT_W + COIN_VAL_W;

  logic [EXT_W-1:0] w_credit_ext;

  assign w_credit_ext = EXT_W'(i_credit);

  always_comb begin
    o_code = COIN_5;
    if (w_credit_ext >= EXT_W'(coin_value(COIN_100)))
      o_code = COIN_100;
    else if (w_credit_ext >= EXT_W'(coin_value(COIN_50)))
      o_code = COIN_50;
    else if (w_credit_ext >= EXT_W'(coin_value(COIN_10)))
      o_code = COIN_10;
  end

  // Credit is always a multiple of 5 here, so the subtraction never underflows.
  assign o_remain = CREDIT_W'(w_credit_ext - EXT_W'(coin_value(o_code)));

endmodule

// File: rtl/vend_multi.sv
// Multi-item vending controller: credit, per-item stock, vend pulse and greedy change.
// All outputs registered, one-cycle latency; no backpressure, pulse inputs are judged every cycle.
module vend_multi
  import vend_pkg::*;
#(
  parameter int  N_ITEMS    = 4,
  parameter int  PRICE_BASE = 30,
  parameter int  MAX_CREDIT = 200,
  parameter int  DEPTH      = 3,
  parameter int  CREDIT_W   = 8,
  localparam int SEL_W      = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_coin,
  input  logic [1:0]          i_coin_val,
  input  logic                i_buy,
  input  logic [SEL_W-1:0]    i_buy_sel,
  input  logic                i_cancel,
  input  logic                i_refill,
  input  logic [SEL_W-1:0]    i_refill_sel,
  output logic                o_coffee,
  output logic [SEL_W-1:0]    o_vend_item,
  output logic                o_return,
  output logic [1:0]          o_return_val,
  output logic                o_coin_reject,
  output logic                o_buy_nack,
  output logic                o_busy,
  output logic [CREDIT_W-1:0] o_credit
);

  localparam int STK_W = (DEPTH > 0) ? $clog2(DEPTH + 1) : 1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W-1:0] w_credit_nxt;
  logic [STK_W-1:0]    r_stock     [N_ITEMS];
  logic [STK_W-1:0]    w_stock_nxt [N_ITEMS];

  logic                r_coffee;
  logic                w_coffee_nxt;
  logic [SEL_W-1:0]    r_vend_item;
  logic [SEL_W-1:0]    w_vend_item_nxt;
  logic                r_return;
  logic                w_return_nxt;
  logic [1:0]          r_return_val;
  logic [1:0]          w_return_val_nxt;
  logic                r_coin_reject;
  logic                w_coin_reject_nxt;
  logic                r_buy_nack;
  logic                w_buy_nack_nxt;
  logic                r_busy;

  logic [31:0]         w_price;
  logic [31:0]         w_coin_sum;
  logic [STK_W-1:0]    w_sel_stock;
  logic                w_buy_in_range;
  logic                w_refill_in_range;
  logic                w_buy_ok;
  logic                w_cancel_hit;
  logic [1:0]          w_chg_code;
  logic [CREDIT_W-1:0] w_chg_remain;

  vend_change_gen #(
    .CREDIT_W (CREDIT_W)
  ) u_change_gen (
    .i_credit (r_credit),
    .o_code   (w_chg_code),
    .o_remain (w_chg_remain)
  );

  // 32-bit arithmetic keeps the overflow check exact for any credit width.
  assign w_price           = 32'(PRICE_BASE) * (32'(i_buy_sel) + 32'd1);
  assign w_coin_sum        = 32'(r_credit) + 32'(coin_value(i_coin_val));
  assign w_buy_in_range    = 32'(i_buy_sel) < 32'(N_ITEMS);
  assign w_refill_in_range = 32'(i_refill_sel) < 32'(N_ITEMS);
  assign w_cancel_hit      = i_cancel && (r_state == ST_CREDIT);
  assign w_buy_ok          = w_buy_in_range && (32'(r_credit) >= w_price) && (w_sel_stock != '0);

  always_comb begin
    w_sel_stock = '0;
    for (int k = 0; k < N_ITEMS; k++) begin
      if (SEL_W'(k) == i_buy_sel) w_sel_stock = r_stock[k];
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_credit_nxt      = r_credit;
    w_coffee_nxt      = 1'b0;
    w_vend_item_nxt   = r_vend_item;
    w_return_nxt      = 1'b0;
    w_return_val_nxt  = r_return_val;
    w_coin_reject_nxt = 1'b0;
    w_buy_nack_nxt    = 1'b0;
    for (int k = 0; k < N_ITEMS; k++) w_stock_nxt[k] = r_stock[k];

    case (r_state)
      ST_IDLE, ST_CREDIT: begin
        if (w_cancel_hit) begin
          w_state_nxt       = ST_CHANGE;
          w_buy_nack_nxt    = i_buy;
          w_coin_reject_nxt = i_coin;
        end else if (i_buy) begin
          // A buy claims the cycle whether or not it succeeds; any coin alongside it is refused.
          w_coin_reject_nxt = i_coin;
          if (w_buy_ok) begin
            w_coffee_nxt    = 1'b1;
            w_vend_item_nxt = i_buy_sel;
            w_credit_nxt    = CREDIT_W'(32'(r_credit) - w_price);
            w_state_nxt     = ST_VEND;
            for (int k = 0; k < N_ITEMS; k++) begin
              if (SEL_W'(k) == i_buy_sel) w_stock_nxt[k] = r_stock[k] - STK_W'(1);
            end
          end else begin
            w_buy_nack_nxt = 1'b1;
          end
        end else if (i_coin) begin
          if (w_coin_sum <= 32'(MAX_CREDIT)) begin
            w_credit_nxt = CREDIT_W'(w_coin_sum);
            w_state_nxt  = ST_CREDIT;
          end else begin
            w_coin_reject_nxt = 1'b1;
          end
        end

        if ((r_state == ST_IDLE) && i_refill && w_refill_in_range) begin
          for (int k = 0; k < N_ITEMS; k++) begin
            if (SEL_W'(k) == i_refill_sel) w_stock_nxt[k] = STK_W'(DEPTH);
          end
        end
      end

      ST_VEND: begin
        w_coin_reject_nxt = i_coin;
        w_state_nxt       = (r_credit != '0) ? ST_CHANGE : ST_IDLE;
      end

      ST_CHANGE: begin
        w_coin_reject_nxt = i_coin;
        w_return_nxt      = 1'b1;
        w_return_val_nxt  = w_chg_code;
        w_credit_nxt      = w_chg_remain;
        if (w_chg_remain == '0) w_state_nxt = ST_IDLE;
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_credit      <= '0;
      r_coffee      <= 1'b0;
      r_vend_item   <= '0;
      r_return      <= 1'b0;
      r_return_val  <= '0;
      r_coin_reject <= 1'b0;
      r_buy_nack    <= 1'b0;
      r_busy        <= 1'b0;
      for (int k = 0; k < N_ITEMS; k++) r_stock[k] <= STK_W'(DEPTH);
    end else begin
      r_state       <= w_state_nxt;
      r_credit      <= w_credit_nxt;
      r_coffee      <= w_coffee_nxt;
      r_vend_item   <= w_vend_item_nxt;
      r_return      <= w_return_nxt;
      r_return_val  <= w_return_val_nxt;
      r_coin_reject <= w_coin_reject_nxt;
      r_buy_nack    <= w_buy_nack_nxt;
      r_busy        <= (w_state_nxt == ST_VEND) || (w_state_nxt == ST_CHANGE);
      for (int k = 0; k < N_ITEMS; k++) r_stock[k] <= w_stock_nxt[k];
    end
  end

  assign o_coffee      = r_coffee;
  assign o_vend_item   = r_vend_item;
  assign o_return      = r_return;
  assign o_return_val  = r_return_val;
  assign o_coin_reject = r_coin_reject;
  assign o_buy_nack    = r_buy_nack;
  assign o_busy        = r_busy;
  assign o_credit      = r_credit;

endmodule

// File: tb/tb_vend_multi.sv
// Bench for vend_multi: a transaction-level model expands each accepted buy or cancel
// into its full timeline of expected cycles; a monitor compares every cycle's outputs.
module tb_vend_multi;

  localparam int N_ITEMS    = 4;
  localparam int PRICE_BASE = 30;
  localparam int MAX_CREDIT = 200;
  localparam int DEPTH      = 3;
  localparam int CREDIT_W   = 8;

  logic       clk = 1'b0;
  logic       rst_n, coin, buy, cancel, refill;
  logic [1:0] coin_val, buy_sel, refill_sel;
  logic       coffee, ret, coin_reject, buy_nack, busy;
  logic [1:0] vend_item, return_val;
  logic [7:0] credit;

  always #5 clk = ~clk;

  vend_multi #(
    .N_ITEMS    (N_ITEMS),
    .PRICE_BASE (PRICE_BASE),
    .MAX_CREDIT (MAX_CREDIT),
    .DEPTH      (DEPTH),
    .CREDIT_W   (CREDIT_W)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_coin        (coin),
    .i_coin_val    (coin_val),
    .i_buy         (buy),
    .i_buy_sel     (buy_sel),
    .i_cancel      (cancel),
    .i_refill      (refill),
    .i_refill_sel  (refill_sel),
    .o_coffee      (coffee),
    .o_vend_item   (vend_item),
    .o_return      (ret),
    .o_return_val  (return_val),
    .o_coin_reject (coin_reject),
    .o_buy_nack    (buy_nack),
    .o_busy        (busy),
    .o_credit      (credit)
  );

  typedef struct {
    bit coffee;
    int item;
    bit ret;
    int rval;
    bit rej;
    bit nack;
    bit busy;
    int credit;
  } exp_t;

  exp_t exp_q[$];   // scoreboard: one expected record per clock edge
  exp_t tl[$];      // future cycles already committed by a vend or cancel
  int   m_credit;
  int   m_stock[N_ITEMS];
  int   errors = 0;
  int   checks = 0;
  exp_t mon_e;

  function automatic int coin_units(input int code);
    case (code)
      0:       return 5;
      1:       return 10;
      2:       return 50;
      default: return 100;
    endcase
  endfunction

  function automatic exp_t blank();
    exp_t r;
    r = '{default: 0};
    return r;
  endfunction

  // Pay out an amount greedily with the largest coin that still fits.
  task automatic plan_change(input int amount);
    int   rem;
    int   code;
    exp_t r;
    rem = amount;
    while (rem > 0) begin
      code = 0;
      for (int c = 3; c >= 0; c--) begin
        if (coin_units(c) <= rem) begin
          code = c;
          break;
        end
      end
      rem = rem - coin_units(code);
      r = blank();
      r.ret    = 1'b1;
      r.rval   = code;
      r.busy   = (rem > 0);
      r.credit = rem;
      tl.push_back(r);
    end
  endtask

  task automatic step(input bit c, input int cv, input bit b, input int bs,
                      input bit can, input bit rf, input int rs, input bit rst);
    exp_t e;
    exp_t nr;
    bit   idle_st;
    int   price;
    @(negedge clk);
    #1;
    rst_n      = !rst;
    coin       = c;
    coin_val   = 2'(cv);
    buy        = b;
    buy_sel    = 2'(bs);
    cancel     = can;
    refill     = rf;
    refill_sel = 2'(rs);
    e = blank();
    if (rst) begin
      m_credit = 0;
      for (int k = 0; k < N_ITEMS; k++) m_stock[k] = DEPTH;
      tl.delete();
    end else if (tl.size() > 0) begin
      e = tl.pop_front();
      e.rej = c;
    end else begin
      idle_st  = (m_credit == 0);
      e.credit = m_credit;
      if (can && !idle_st) begin
        e.busy = 1'b1;
        e.nack = b;
        e.rej  = c;
        plan_change(m_credit);
        m_credit = 0;
      end else if (b) begin
        e.rej = c;
        price = PRICE_BASE * (bs + 1);
        if (bs < N_ITEMS && m_credit >= price && m_stock[bs] > 0) begin
          m_stock[bs] = m_stock[bs] - 1;
          e.coffee = 1'b1;
          e.item   = bs;
          e.busy   = 1'b1;
          e.credit = m_credit - price;
          nr = blank();
          nr.busy   = (e.credit > 0);
          nr.credit = e.credit;
          tl.push_back(nr);
          plan_change(e.credit);
          m_credit = 0;
        end else begin
          e.nack = 1'b1;
        end
      end else if (c) begin
        if (m_credit + coin_units(cv) <= MAX_CREDIT) m_credit = m_credit + coin_units(cv);
        else e.rej = 1'b1;
        e.credit = m_credit;
      end
      if (rf && idle_st && rs < N_ITEMS) m_stock[rs] = DEPTH;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic put(input int cv);
    step(1, cv, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic purchase(input int s);
    step(0, 0, 1, s, 0, 0, 0, 0);
  endtask

  task automatic do_cancel();
    step(0, 0, 0, 0, 1, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (coffee !== mon_e.coffee || ret !== mon_e.ret || coin_reject !== mon_e.rej ||
          buy_nack !== mon_e.nack || busy !== mon_e.busy || credit !== 8'(mon_e.credit) ||
          (mon_e.coffee && vend_item !== 2'(mon_e.item)) ||
          (mon_e.ret && return_val !== 2'(mon_e.rval))) begin
        errors++;
        $display("FAIL outputs at check %0d: got coffee=%0b item=%0d return=%0b rval=%0d reject=%0b nack=%0b busy=%0b credit=%0d, want coffee=%0b item=%0d return=%0b rval=%0d reject=%0b nack=%0b busy=%0b credit=%0d",
                 checks, coffee, vend_item, ret, return_val, coin_reject, buy_nack, busy, credit,
                 mon_e.coffee, mon_e.item, mon_e.ret, mon_e.rval, mon_e.rej, mon_e.nack,
                 mon_e.busy, mon_e.credit);
      end
    end
  end

  initial begin
    rst_n = 1'b0; coin = 1'b0; coin_val = '0; buy = 1'b0; buy_sel = '0;
    cancel = 1'b0; refill = 1'b0; refill_sel = '0;
    m_credit = 0;
    for (int k = 0; k < N_ITEMS; k++) m_stock[k] = DEPTH;

    do_reset();
    do_reset();
    idle(2);

    // 50+50, buy item 1 (60): change of 40 as four tens
    put(2); put(2); purchase(1); idle(7);

    // credit at the ceiling refuses a 5, cancel returns 100,100
    put(3); put(3); put(0); do_cancel(); idle(4);

    // credit 10 cannot buy item 0
    put(1); purchase(0); do_cancel(); idle(3);

    // drain item 0, then the fourth buy is refused until a refill
    repeat (3) begin
      put(3); purchase(0); idle(6);
    end
    put(3); purchase(0); do_cancel(); idle(3);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    put(3); purchase(0); idle(6);

    // buy and coin in the same cycle: buy wins, coin refused
    put(2); step(1, 1, 1, 0, 0, 0, 0, 0); idle(5);

    // reset while paying out 90
    do_reset();
    put(3); put(2); purchase(1); idle(1);
    do_reset();
    idle(3);

    // idle-state cancel is ignored, busy-state coins are refused
    do_cancel();
    put(3); purchase(0); put(1); put(1); idle(6);

    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 99) < 40, $urandom_range(0, 3),
           $urandom_range(0, 99) < 15, $urandom_range(0, 3),
           $urandom_range(0, 99) < 5,
           $urandom_range(0, 99) < 8, $urandom_range(0, 3),
           $urandom_range(0, 199) == 0);
    end
    idle(10);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected records left unchecked, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
